aq_calc_size_seq: RTL and testbench

AQ_CALC_SIZE_SEQ -- requirements
Module: aq_calc_size_seq

---
 rtl/aq_calc_size_pkg.sv | 12 +
 rtl/aq_calc_size_seq_if.sv | 32 +++
 rtl/aq_calc_size_step.sv | 34 +++
 rtl/aq_calc_size_seq.sv | 104 ++++++++++
 tb/tb_aq_calc_size_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/aq_calc_size_pkg.sv
// Shared definitions for the size-conversion coefficient sequencer:
// the default field width and the two-state controller encoding.
package aq_calc_size_pkg;

  localparam int AQ_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/aq_calc_size_seq_if.sv
// Command and coefficient-record bundle between a line controller and the sequencer.
// The slave side is the sequencer; the master side issues START and consumes records.
interface aq_calc_size_seq_if
  import aq_calc_size_pkg::*;
#(
  parameter int W = AQ_W
);

  logic         START;
  logic [W-1:0] ORG;
  logic [W-1:0] CNV;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] MA;
  logic [W-1:0] MB;
  logic         CLOSE;
  logic         LAST;
  logic         BUSY;
  logic         DONE;
  logic         ERR;

  modport master (
    output START, ORG, CNV, OUT_READY,
    input  OUT_VALID, MA, MB, CLOSE, LAST, BUSY, DONE, ERR
  );

  modport slave (
    input  START, ORG, CNV, OUT_READY,
    output OUT_VALID, MA, MB, CLOSE, LAST, BUSY, DONE, ERR
  );

endinterface

// File: rtl/aq_calc_size_step.sv
// One step of the resampling weight walk: given the remainder r of the current
// source sample, produce the two bin weights and the remainder for the next sample.
module aq_calc_size_step
  import aq_calc_size_pkg::*;
#(
  parameter int W = AQ_W
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] cnv,
  input  logic [W-1:0] org,
  output logic [W-1:0] ma,
  output logic [W-1:0] mb,
  output logic         close,
  output logic [W-1:0] r_next
);

  // A bin spills over into the next one only when cnv exceeds what is left of r.
  always_comb begin
    ma     = cnv;
    mb     = '0;
    close  = 1'b0;
    r_next = r - cnv;
    if (cnv == r) begin
      close  = 1'b1;
      r_next = org;
    end else if (cnv > r) begin
      ma     = r;
      mb     = cnv - r;
      close  = 1'b1;
      r_next = org - (cnv - r);
    end
  end

endmodule

// File: rtl/aq_calc_size_seq.sv
// Emits one coefficient record per source sample of a line, with valid/ready
// back-pressure, a done pulse at end of line and a sticky configuration error.
module aq_calc_size_seq
  import aq_calc_size_pkg::*;
#(
  parameter int W = AQ_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  aq_calc_size_seq_if.slave bus
);

  state_e       state;
  logic [W-1:0] org_q;
  logic [W-1:0] cnv_q;
  logic [W-1:0] r_q;
  logic [W-1:0] n_q;

  logic         cfg_ok;
  logic         hs;
  logic [W-1:0] s_r;
  logic [W-1:0] s_cnv;
  logic [W-1:0] s_org;
  logic [W-1:0] s_ma;
  logic [W-1:0] s_mb;
  logic         s_close;
  logic [W-1:0] s_r_next;

  assign cfg_ok = (bus.CNV != '0) && (bus.CNV <= bus.ORG);
  assign hs     = bus.OUT_VALID && bus.OUT_READY;

  // r_q holds the remainder for the record after the one on the outputs,
  // so a new START seeds the step directly from ORG instead.
  assign s_r   = bus.START ? bus.ORG : r_q;
  assign s_cnv = bus.START ? bus.CNV : cnv_q;
  assign s_org = bus.START ? bus.ORG : org_q;

  aq_calc_size_step #(.W(W)) u_step (
    .r      (s_r),
    .cnv    (s_cnv),
    .org    (s_org),
    .ma     (s_ma),
    .mb     (s_mb),
    .close  (s_close),
    .r_next (s_r_next)
  );

  // START wins over a simultaneous handshake, which is how a running line is aborted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      org_q         <= '0;
      cnv_q         <= '0;
      r_q           <= '0;
      n_q           <= '0;
      bus.OUT_VALID <= 1'b0;
      bus.MA        <= '0;
      bus.MB        <= '0;
      bus.CLOSE     <= 1'b0;
      bus.LAST      <= 1'b0;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
      bus.ERR       <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      if (bus.START) begin
        if (cfg_ok) begin
          state         <= RUN;
          org_q         <= bus.ORG;
          cnv_q         <= bus.CNV;
          n_q           <= '0;
          r_q           <= s_r_next;
          bus.MA        <= s_ma;
          bus.MB        <= s_mb;
          bus.CLOSE     <= s_close;
          bus.LAST      <= (bus.ORG == W'(1));
          bus.OUT_VALID <= 1'b1;
          bus.BUSY      <= 1'b1;
          bus.ERR       <= 1'b0;
        end else begin
          state         <= IDLE;
          bus.OUT_VALID <= 1'b0;
          bus.BUSY      <= 1'b0;
          bus.ERR       <= 1'b1;
        end
      end else if (state == RUN && hs) begin
        if (bus.LAST) begin
          state         <= IDLE;
          bus.OUT_VALID <= 1'b0;
          bus.BUSY      <= 1'b0;
          bus.DONE      <= 1'b1;
        end else begin
          n_q       <= n_q + W'(1);
          r_q       <= s_r_next;
          bus.MA    <= s_ma;
          bus.MB    <= s_mb;
          bus.CLOSE <= s_close;
          bus.LAST  <= (n_q + W'(2) == org_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_aq_calc_size_seq.sv
// Scoreboard bench for aq_calc_size_seq: directed lines push hand-computed records,
// a negedge monitor pops and compares every accepted record and checks DONE timing.
module tb_aq_calc_size_seq;
  import aq_calc_size_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic         close;
    logic         last;
  } rec_t;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  aq_calc_size_seq_if #(.W(W)) bus ();

  aq_calc_size_seq #(.W(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  rec_t sb[$];
  rec_t pend[$];
  int   checks = 0;
  int   passes = 0;
  bit   done_due = 1'b0;
  bit   exp_done;
  rec_t e;
  rec_t act;
  bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  function automatic rec_t mkRec(input int ma, input int mb, input bit close, input bit last);
    rec_t r;
    r.ma    = W'(ma);
    r.mb    = W'(mb);
    r.close = close;
    r.last  = last;
    return r;
  endfunction

  // Records are queued only after START is sampled, so an aborted line's tail never matches.
  task automatic applyStimulus(input int org, input int cnv, input bit ready, input bit expect_run);
    bus.ORG   = W'(org);
    bus.CNV   = W'(cnv);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START     = 1'b0;
    bus.OUT_READY = ready;
    while (pend.size() != 0) sb.push_back(pend.pop_front());
    checkOutput("start_valid", 64'(bus.OUT_VALID), 64'(expect_run));
    checkOutput("start_busy", 64'(bus.BUSY), 64'(expect_run));
    checkOutput("start_err", 64'(bus.ERR), 64'(!expect_run));
  endtask

  task automatic waitDrain(input int remain, input bit stall);
    for (int i = 1; i <= 200 && sb.size() > remain; i++) begin
      @(posedge CLK); #1;
      if (stall) bus.OUT_READY = pat[i % 4];
    end
    if (sb.size() > remain) begin
      checks++;
      $display("[TB] FAIL drain_timeout: %0d records left, required %0d", sb.size(), remain);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.OUT_VALID), 64'(0));
    checkOutput({tag, "_ma"}, 64'(bus.MA), 64'(0));
    checkOutput({tag, "_mb"}, 64'(bus.MB), 64'(0));
    checkOutput({tag, "_close"}, 64'(bus.CLOSE), 64'(0));
    checkOutput({tag, "_last"}, 64'(bus.LAST), 64'(0));
    checkOutput({tag, "_busy"}, 64'(bus.BUSY), 64'(0));
    checkOutput({tag, "_done"}, 64'(bus.DONE), 64'(0));
    checkOutput({tag, "_err"}, 64'(bus.ERR), 64'(0));
  endtask

  // Monitor: compare on accept, check hold during stalls, and expect DONE right after LAST.
  always @(negedge CLK) begin
    if (RST_N) begin
      exp_done = done_due;
      done_due = 1'b0;
      act = {bus.MA, bus.MB, bus.CLOSE, bus.LAST};
      if (exp_done || bus.DONE) checkOutput("done", 64'(bus.DONE), 64'(exp_done));
      if (exp_done) checkOutput("valid_after_last", 64'(bus.OUT_VALID), 64'(0));
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_record: got %h, required no valid record", act);
        end else begin
          e = sb.pop_front();
          checkOutput("record", 64'(act), 64'(e));
          if (e.last) done_due = 1'b1;
        end
      end else if (bus.OUT_VALID && sb.size() != 0) begin
        checkOutput("stall_hold", 64'(act), 64'(sb[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.START     = 1'b0;
    bus.ORG       = '0;
    bus.CNV       = '0;
    bus.OUT_READY = 1'b1;
    RST_N         = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkCleared("reset");
    RST_N = 1'b1;
    idle(1);

    $display("[TB] line ORG=5 CNV=2");
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 1, 1));
    applyStimulus(5, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("[TB] line ORG=4 CNV=4");
    for (int i = 0; i < 4; i++) pend.push_back(mkRec(4, 0, 1, (i == 3)));
    applyStimulus(4, 4, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("[TB] line ORG=3 CNV=2");
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    pend.push_back(mkRec(2, 0, 1, 1));
    applyStimulus(3, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("[TB] line ORG=5 CNV=2 with stalls");
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 1, 1));
    applyStimulus(5, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b1);
    bus.OUT_READY = 1'b1;
    idle(3);

    $display("[TB] configuration errors");
    applyStimulus(3, 0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(3, 5, 1'b1, 1'b0);
    idle(2);
    checkOutput("err_sticky", 64'(bus.ERR), 64'(1));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    pend.push_back(mkRec(2, 0, 1, 1));
    applyStimulus(3, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("[TB] abort by START mid-line");
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    applyStimulus(5, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    bus.OUT_READY = 1'b0;
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 1, 1));
    applyStimulus(5, 2, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("[TB] reset mid-line");
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(2, 0, 0, 0));
    pend.push_back(mkRec(1, 1, 1, 0));
    applyStimulus(5, 2, 1'b1, 1'b1);
    waitDrain(2, 1'b0);
    RST_N = 1'b0;
    sb.delete();
    #1;
    checkCleared("midreset");
    idle(1);
    RST_N = 1'b1;
    idle(1);

    $display("[TB] single-sample line ORG=1 CNV=1 after reset");
    pend.push_back(mkRec(1, 0, 1, 1));
    applyStimulus(1, 1, 1'b1, 1'b1);
    waitDrain(0, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
